// File: rtl/alu_pkg.sv
// Shared ALU constants, function codes and arbiter FSM state type.
package alu_pkg;
  localparam int ALU_W  = 16;
  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FN_ADD  = 4'd0;
  localparam logic [FUNC_W-1:0] FN_SUB  = 4'd1;
  localparam logic [FUNC_W-1:0] FN_AND  = 4'd2;
  localparam logic [FUNC_W-1:0] FN_OR   = 4'd3;
  localparam logic [FUNC_W-1:0] FN_XOR  = 4'd4;
  localparam logic [FUNC_W-1:0] FN_NOTA = 4'd5;
  localparam logic [FUNC_W-1:0] FN_SHL  = 4'd6;
  localparam logic [FUNC_W-1:0] FN_SHR  = 4'd7;
  localparam logic [FUNC_W-1:0] FN_SRA  = 4'd8;
  localparam logic [FUNC_W-1:0] FN_SLT  = 4'd9;
  localparam logic [FUNC_W-1:0] FN_SLTU = 4'd10;
  localparam logic [FUNC_W-1:0] FN_PASA = 4'd11;
  localparam logic [FUNC_W-1:0] FN_PASB = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;
endpackage

// File: rtl/alu_arbiter_alu16.sv
// ALU16bit: purely combinational 16-bit ALU; unused function codes yield zero.
module ALU16bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]  i_a,
  input  logic [ALU_W-1:0]  i_b,
  input  logic [FUNC_W-1:0] i_func,
  output logic [ALU_W-1:0]  o_y
);
  logic signed [ALU_W-1:0] w_sa;
  logic signed [ALU_W-1:0] w_sb;

  assign w_sa = i_a;
  assign w_sb = i_b;

  always_comb begin
    o_y = '0;
    case (i_func)
      FN_ADD:  o_y = i_a + i_b;
      FN_SUB:  o_y = i_a - i_b;
      FN_AND:  o_y = i_a & i_b;
      FN_OR:   o_y = i_a | i_b;
      FN_XOR:  o_y = i_a ^ i_b;
      FN_NOTA: o_y = ~i_a;
      // Shift amounts use only the low 4 bits of B.
      FN_SHL:  o_y = i_a << i_b[3:0];
      FN_SHR:  o_y = i_a >> i_b[3:0];
      FN_SRA:  o_y = w_sa >>> i_b[3:0];
      FN_SLT:  o_y = {{(ALU_W-1){1'b0}}, (w_sa < w_sb)};
      FN_SLTU: o_y = {{(ALU_W-1){1'b0}}, (i_a < i_b)};
      FN_PASA: o_y = i_a;
      FN_PASB: o_y = i_b;
      default: o_y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU16bit among N_REQ requesters, 1-cycle result latency.
// Optional grant counter op_count enabled by defining ALU_ARBITER_STATS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  input  logic [N_REQ*FUNC_W-1:0]  req_func,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [15:0]              op_count
`endif
);
  localparam int ID_W = $clog2(N_REQ);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_rsp_id;
  logic [W-1:0]      r_rsp_data;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_idx;
  logic [ID_W:0]     w_sum;
  logic              w_found;
  logic              w_can_accept;
  logic              w_grant;
  logic [W-1:0]      w_alu_a;
  logic [W-1:0]      w_alu_b;
  logic [W-1:0]      w_alu_y;
  logic [FUNC_W-1:0] w_alu_func;

  assign w_can_accept = (r_state == ST_IDLE) | rsp_ready;
  assign w_grant      = rst_n & w_can_accept & w_found;

  // Scan upward from r_rr_ptr with wrap; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win] = 1'b1;
  end

  assign w_alu_a    = req_a[w_win*W +: W];
  assign w_alu_b    = req_b[w_win*W +: W];
  assign w_alu_func = req_func[w_win*FUNC_W +: FUNC_W];

  ALU16bit u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_func (w_alu_func),
    .o_y    (w_alu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_grant)        w_state_nxt = ST_FULL;
        else if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result, owner id and pointer only move on a grant, so a stalled result stays frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rr_ptr   <= '0;
    end else if (w_grant) begin
      r_rsp_data <= w_alu_y;
      r_rsp_id   <= w_win;
      r_rr_ptr   <= (w_win == ID_W'(N_REQ-1)) ? '0 : w_win + ID_W'(1);
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk) begin
    if (!rst_n)                              r_op_count <= '0;
    else if (w_grant && r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter with a result scoreboard; op_count check under ALU_ARBITER_STATS_EN.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] req_func;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] op_count;
`endif

  alu_arbiter #(.N_REQ(4), .W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_func  (req_func),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef ALU_ARBITER_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  exp;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] f;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  id;
  } rsp_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic m_full = 1'b0;
  rsp_t sb[$];
  vec_t tbl[19];

  localparam logic [3:0] TV [19] = '{4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA,
                                     4'hA, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h9, 4'h0};
  localparam logic       TR [19] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [3:0] TE [19] = '{4'h1, 4'h0, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h2, 4'h8,
                                     4'h2, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0};

  function automatic logic [15:0] gold(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    logic signed [15:0] sa;
    logic signed [15:0] sb_;
    sa  = a;
    sb_ = b;
    case (f)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return a << b[3:0];
      4'd7:  return a >> b[3:0];
      4'd8:  return 16'(sa >>> b[3:0]);
      4'd9:  return (sa < sb_) ? 16'd1 : 16'd0;
      4'd10: return (a < b) ? 16'd1 : 16'd0;
      4'd11: return a;
      4'd12: return b;
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [15:0] rndf();
    return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction

  task automatic step(input logic [3:0] vld, input logic rdy, input logic [3:0] exp_rdy,
                      input logic [63:0] a, input logic [63:0] b, input logic [15:0] f);
    logic [1:0] w;
    logic       grant;
    rsp_t       e;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = vld;
    rsp_ready = rdy;
    req_a     = a;
    req_b     = b;
    req_func  = f;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    w = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) w = 2'(i);
    grant  = |exp_rdy;
    e.data = gold(a[w*16 +: 16], b[w*16 +: 16], f[w*4 +: 4]);
    e.id   = w;
    @(posedge clk);
    #1;
    if (m_full && rdy && sb.size() > 0) void'(sb.pop_front());
    if (grant) sb.push_back(e);
    m_full = grant || (m_full && !rdy);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full && sb.size() > 0) begin
      chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
      chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
    end
  endtask

  task automatic do_reset(input logic [3:0] vld);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = vld;
    rsp_ready = 1'b1;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    sb.delete();
    m_full = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_func  = '0;

    for (int i = 0; i < 19; i++) begin
      tbl[i].vld = TV[i];
      tbl[i].rdy = TR[i];
      tbl[i].exp = TE[i];
      tbl[i].a   = rnd64();
      tbl[i].b   = rnd64();
      tbl[i].f   = rndf();
    end
    tbl[0].a[15:0] = 16'd20;
    tbl[0].b[15:0] = 16'd38;
    tbl[0].f[3:0]  = 4'd1;

    do_reset(4'hF);
    for (int i = 0; i < 19; i++)
      step(tbl[i].vld, tbl[i].rdy, tbl[i].exp, tbl[i].a, tbl[i].b, tbl[i].f);

    // Continuous requests from all four: grants rotate 0,1,2,3,0.
    do_reset(4'hF);
    step(4'hF, 1'b1, 4'h1, rnd64(), rnd64(), rndf());
    step(4'hF, 1'b1, 4'h2, rnd64(), rnd64(), rndf());
    step(4'hF, 1'b1, 4'h4, rnd64(), rnd64(), rndf());
    step(4'hF, 1'b1, 4'h8, rnd64(), rnd64(), rndf());
    step(4'hF, 1'b1, 4'h1, rnd64(), rnd64(), rndf());

    // Consumer stall for 5 cycles with operands churning, then release.
    do_reset(4'h0);
    step(4'hF, 1'b1, 4'h1, rnd64(), rnd64(), rndf());
    for (int i = 0; i < 5; i++) step(4'hF, 1'b0, 4'h0, rnd64(), rnd64(), rndf());
    step(4'hF, 1'b1, 4'h2, rnd64(), rnd64(), rndf());

    // Reset while FULL with rr_ptr=3; pointer must restart at 0 and no stale result appears.
    do_reset(4'h0);
    step(4'h4, 1'b0, 4'h4, rnd64(), rnd64(), rndf());
    step(4'h0, 1'b0, 4'h0, rnd64(), rnd64(), rndf());
    do_reset(4'hF);
    step(4'h5, 1'b1, 4'h1, rnd64(), rnd64(), rndf());
    step(4'h4, 1'b1, 4'h4, rnd64(), rnd64(), rndf());
    step(4'h0, 1'b1, 4'h0, rnd64(), rnd64(), rndf());

`ifdef ALU_ARBITER_STATS_EN
    do_reset(4'h0);
    chk("op_count_reset", 32'(op_count), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'h1;
    rsp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    chk("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters sharing the ALU (2..8).
- REQ-002 SHALL have parameter W, default 16, meaning operand/result width; only 16 is supported.
- REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1, meaning the synchronous, active-low reset.
- REQ-005 SHALL have port req_valid, input, N_REQ, meaning per-requester operation-valid flags.
- REQ-006 SHALL have port req_ready, output, N_REQ, meaning the one-hot grant (accept) for this cycle.
- REQ-007 SHALL have port req_a, input, N_REQ*16, meaning packed operand A; slice i belongs to requester i.
- REQ-008 SHALL have port req_b, input, N_REQ*16, meaning packed operand B.
- REQ-009 SHALL have port req_func, input, N_REQ*4, meaning packed ALU function codes.
- REQ-010 SHALL have port rsp_valid, output, 1, meaning a result is held.
- REQ-011 SHALL have port rsp_ready, input, 1, meaning the consumer accepts the result.
- REQ-012 SHALL have port rsp_data, output, 16, meaning the registered ALU result.
- REQ-013 SHALL have port rsp_id, output, clog2(N_REQ), meaning the index of the requester owning rsp_data.

Function
- REQ-014 SHALL use a two-state FSM: IDLE (result register empty) and FULL (result held).
- REQ-015 SHALL define can_accept = (state==IDLE) | rsp_ready.
- REQ-016 SHALL assert req_ready[i] only when can_accept is 1, req_valid[i] is 1, and i is the round-robin winner; at most one bit is set, combinationally.
- REQ-017 SHALL search for the round-robin winner starting at rr_ptr and moving upward with wrap; after a grant to i, rr_ptr SHALL become (i+1) mod N_REQ; with no grant, rr_ptr SHALL hold.
- REQ-018 SHALL, on a grant to i, drive the ALU with slice i of a/b/func and register the ALU output into rsp_data and i into rsp_id at the same edge; rsp_valid SHALL be 1 the next cycle, giving 1-cycle latency.
- REQ-019 SHALL go IDLE->FULL on a grant, FULL->FULL on a grant with rsp_ready (back-to-back, full throughput), FULL->IDLE on rsp_ready with no grant, and hold FULL while rsp_ready is 0.
- REQ-020 SHALL keep rsp_data, rsp_id and rsp_valid stable while rsp_valid=1 and rsp_ready=0.
- REQ-021 SHALL let requesters change operands freely while not granted; only the values on the grant cycle count.
- REQ-022 SHALL ignore rsp_ready while IDLE.

Reset
- REQ-023 SHALL, when rst_n=0 at a clock edge, force state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0 and rr_ptr=0; req_ready SHALL be all-zero during reset.
- REQ-024 SHALL discard any held result on reset mid-operation, with no response emitted.

Configuration
- REQ-025 SHALL, with ALU_ARBITER_STATS_EN defined, add output op_count (16 bits): reset to 0, incremented on each grant, saturating at 0xFFFF.
- REQ-026 SHALL, without ALU_ARBITER_STATS_EN, have no op_count port and no counter logic.

Structure
- REQ-027 SHALL place these in a shared package alu_pkg: the ALU width constant (16), the function-code width (4), the named function-code constants, and the FSM state typedef.
- REQ-028 SHALL instantiate exactly one existing ALU16bit as its sub-module; round-robin logic SHALL stay inline.

Verification
- REQ-029 Single request: req0 a=20, b=38, func=1 -> req_ready[0] same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=golden ALU16bit(20,38,1).
- REQ-030 All four requesting continuously with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; one result per cycle with matching ids.
- REQ-031 rsp_ready=0 for 5 cycles after the first result -> req_ready all 0 and rsp_data/rsp_id frozen; on release, the next grant goes to requester rr_ptr.
- REQ-032 Simultaneous req1 and req3 with rr_ptr=2 -> req3 granted first, then req1.
- REQ-033 Reset asserted while FULL -> next cycle rsp_valid=0, rr_ptr=0; a subsequent req2 is granted with no stale response.
- REQ-034 With ALU_ARBITER_STATS_EN defined, 70000 grants -> op_count=0xFFFF.
